// File: rtl/ptp_serializer.sv
// rtl/ptp_serializer.sv - snapshot NUM_WORDS words and emit them as CHUNK_W-bit chunks over valid/ready
// Outputs are decoded from the state, shadow, index and order registers only.
module ptp_serializer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 5,
  parameter int CHUNK_W   = 8,
  localparam int TOTAL_W    = WORD_W * NUM_WORDS,
  localparam int NUM_CHUNKS = TOTAL_W / CHUNK_W,
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               lsb_first_i,
  input  logic               abort_i,
  input  logic [TOTAL_W-1:0] words_i,
  input  logic               ready_i,
  output logic [CHUNK_W-1:0] chunk_o,
  output logic               valid_o,
  output logic [IDX_W-1:0]   index_o,
  output logic               last_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t             state_q, state_d;
  logic [TOTAL_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               order_q, order_d;
  logic               done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      index_q  <= '0;
      order_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      index_q  <= index_d;
      order_q  <= order_d;
      done_q   <= done_d;
    end
  end

  // Abort is tested before the handshake so it wins over a same-cycle transfer.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    index_d  = index_q;
    order_d  = order_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shadow_d = words_i;
          order_d  = lsb_first_i;
          index_d  = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (abort_i) begin
          state_d = IDLE;
          index_d = '0;
        end else if (ready_i) begin
          if (index_q == LAST_IDX) begin
            state_d = IDLE;
            index_d = '0;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  // chunks[i] holds shadow bits [i*CHUNK_W +: CHUNK_W]; MSB-first walks the array from the top.
  logic [CHUNK_W-1:0] chunks [NUM_CHUNKS];
  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
    assign chunks[g] = shadow_q[g*CHUNK_W +: CHUNK_W];
  end

  logic [IDX_W-1:0] sel;
  logic             sending;

  assign sel     = order_q ? index_q : (LAST_IDX - index_q);
  assign sending = (state_q == SEND);

  assign valid_o = sending;
  assign busy_o  = sending;
  assign index_o = index_q;
  assign last_o  = sending && (index_q == LAST_IDX);
  assign chunk_o = sending ? chunks[sel] : '0;
  assign done_o  = done_q;

endmodule

// File: tb/tb_ptp_serializer.sv
// tb/tb_ptp_serializer.sv - randomized bench for ptp_serializer against a transfer-level reference model
module tb_ptp_serializer;
  localparam int TW = 160;
  localparam int NC = 20;
  localparam int CW = 8;
  localparam int IW = 5;
  localparam logic [TW-1:0] DEF = 160'h11223344_55667788_99AABBCC_DDEEFF00_0A0B0C0D;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic          lsb_first_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [TW-1:0] words_i = '0;
  logic          ready_i = 1'b0;
  logic [CW-1:0] chunk_o;
  logic          valid_o;
  logic [IW-1:0] index_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk = ~clk;

  ptp_serializer dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .lsb_first_i(lsb_first_i),
    .abort_i    (abort_i),
    .words_i    (words_i),
    .ready_i    (ready_i),
    .chunk_o    (chunk_o),
    .valid_o    (valid_o),
    .index_o    (index_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  // Reference model: one transfer = snapshot + count of chunks accepted so far.
  bit            m_busy = 0;
  bit            m_done = 0;
  bit            m_lsb  = 0;
  int            m_k    = 0;
  logic [TW-1:0] m_snap = '0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CW-1:0] obs_q[$];
  logic [CW-1:0] ref1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [CW-1:0] exp_chunk(input logic [TW-1:0] w, input bit lsb, input int k);
    logic [TW-1:0] t;
    if (lsb) t = w >> (k * CW);
    else     t = w >> (TW - (k + 1) * CW);
    return t[CW-1:0];
  endfunction

  function automatic logic [TW-1:0] rand_words();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cycle(input bit rst, input bit st, input bit lsb, input bit ab,
                       input bit rdy, input logic [TW-1:0] w);
    reset_i = rst; start_i = st; lsb_first_i = lsb; abort_i = ab; ready_i = rdy; words_i = w;
    if (!rst && valid_o && rdy && !ab) obs_q.push_back(chunk_o);
    if (rst) begin
      m_busy = 0; m_k = 0; m_done = 0; m_snap = '0; m_lsb = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (st) begin m_snap = w; m_lsb = lsb; m_k = 0; m_busy = 1; end
    end else begin
      m_done = 0;
      if (ab) begin
        m_busy = 0; m_k = 0;
      end else if (rdy) begin
        if (m_k == NC - 1) begin m_busy = 0; m_k = 0; m_done = 1; end
        else m_k++;
      end
    end
    @(posedge clk); #1;
    check("valid", 32'(valid_o), 32'(m_busy));
    check("busy",  32'(busy_o),  32'(m_busy));
    check("index", 32'(index_o), 32'(m_k));
    check("chunk", 32'(chunk_o), m_busy ? 32'(exp_chunk(m_snap, m_lsb, m_k)) : 32'd0);
    check("last",  32'(last_o),  32'(m_busy && m_k == NC - 1));
    check("done",  32'(done_o),  32'(m_done));
  endtask

  task automatic drain_random_ready(input bit lsb, input bit noisy);
    int guard;
    cycle(0, 1, lsb, 0, 1, DEF);
    guard = 0;
    while (m_busy && guard < 300) begin
      cycle(0, noisy ? bit'($urandom % 2) : 1'b0, ~lsb, 0, bit'($urandom % 2),
            noisy ? rand_words() : DEF);
      guard++;
    end
    check("drain_timeout", 32'(m_busy), 32'd0);
  endtask

  task automatic compare_ref1(input string tag);
    check({tag, "_len"}, 32'(obs_q.size()), 32'(NC));
    for (int i = 0; i < NC && i < obs_q.size(); i++)
      check(tag, 32'(obs_q[i]), 32'(ref1[i]));
  endtask

  initial begin
    int guard;
    // Reset with every other input active: reset must win.
    repeat (2) cycle(1, 1, 1, 1, 1, DEF);
    check("rst_chunk", 32'(chunk_o), 32'd0);

    // 1: MSB-first, ready always high
    obs_q.delete();
    cycle(0, 1, 0, 0, 1, DEF);
    check("t1_latency", 32'(valid_o), 32'd1);
    repeat (22) cycle(0, 0, 0, 0, 1, DEF);
    check("t1_len", 32'(obs_q.size()), 32'(NC));
    if (obs_q.size() == NC) begin
      check("t1_c0",  32'(obs_q[0]),  32'h11);
      check("t1_c3",  32'(obs_q[3]),  32'h44);
      check("t1_c15", 32'(obs_q[15]), 32'h00);
      check("t1_c19", 32'(obs_q[19]), 32'h0D);
    end
    ref1 = obs_q;

    // 2: LSB-first
    obs_q.delete();
    cycle(0, 1, 1, 0, 1, DEF);
    repeat (22) cycle(0, 0, 0, 0, 1, DEF);
    check("t2_len", 32'(obs_q.size()), 32'(NC));
    if (obs_q.size() == NC) begin
      check("t2_c0",  32'(obs_q[0]),  32'h0D);
      check("t2_c3",  32'(obs_q[3]),  32'h0A);
      check("t2_c4",  32'(obs_q[4]),  32'h00);
      check("t2_c5",  32'(obs_q[5]),  32'hFF);
      check("t2_c19", 32'(obs_q[19]), 32'h11);
    end

    // 3: random ready
    obs_q.delete();
    drain_random_ready(0, 0);
    compare_ref1("t3_seq");

    // 4: start pulses and new words during SEND
    obs_q.delete();
    drain_random_ready(0, 1);
    compare_ref1("t4_seq");
    repeat (2) cycle(0, 0, 0, 0, 1, DEF);

    // 5: reset at index 7, then abort at index 3
    cycle(0, 1, 0, 0, 1, DEF);
    guard = 0;
    while (m_k < 7 && guard < 30) begin cycle(0, 0, 0, 0, 1, DEF); guard++; end
    check("t5_reach7", 32'(index_o), 32'd7);
    cycle(1, 0, 0, 0, 1, DEF);
    repeat (2) cycle(0, 0, 0, 0, 1, DEF);
    cycle(0, 1, 0, 0, 1, DEF);
    guard = 0;
    while (m_k < 3 && guard < 30) begin cycle(0, 0, 0, 0, 1, DEF); guard++; end
    check("t5_reach3", 32'(index_o), 32'd3);
    cycle(0, 0, 0, 1, 1, DEF);
    repeat (3) cycle(0, 0, 0, 1, 1, DEF);

    // 6: start held high -> back-to-back transfers with one idle cycle
    obs_q.delete();
    repeat (45) cycle(0, 1, 0, 0, 1, DEF);
    check("t6_len", 32'(obs_q.size() >= 21), 32'd1);
    if (obs_q.size() >= 21) check("t6_second", 32'(obs_q[20]), 32'h11);
    repeat (25) cycle(0, 0, 0, 0, 1, DEF);

    // Fully random traffic
    for (int i = 0; i < 500; i++)
      cycle(($urandom % 60) == 0, ($urandom % 4) == 0, bit'($urandom % 2),
            ($urandom % 25) == 0, bit'($urandom % 2), rand_words());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
